// File: rtl/dct_quant_zigzag.sv
// dct_quant_zigzag: takes one 8x8 DCT coefficient block per handshake. Each
// coefficient is quantized with the JPEG luminance table (quality 50) by
// multiplying with a rounded reciprocal. The results stream out one per beat
// in JPEG zigzag order.
module dct_quant_zigzag #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 12,
  parameter int RECIP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [64*IN_W-1:0]   in_block,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic [5:0]           out_index,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int RECIP_FRAC = 16;
  localparam int PROD_W     = IN_W + 1 + RECIP_W;
  localparam int QMAG_W     = PROD_W - RECIP_FRAC;

  // Annex K luminance quantization table, raster order
  localparam int unsigned QTAB [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };

  // Zigzag position k -> raster index
  localparam int unsigned ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  typedef logic [63:0][RECIP_W-1:0] recip_rom_t;

  // Reciprocal ROM contents, rounded to nearest, folded at elaboration time
  function automatic recip_rom_t build_recip();
    recip_rom_t rom;
    for (int i = 0; i < 64; i++) begin
      rom[i] = RECIP_W'(((1 << RECIP_FRAC) + QTAB[i] / 2) / QTAB[i]);
    end
    return rom;
  endfunction

  localparam recip_rom_t RECIP = build_recip();

  localparam logic [QMAG_W-1:0] POS_LIM = QMAG_W'((1 << (OUT_W - 1)) - 1);
  localparam logic [QMAG_W-1:0] NEG_LIM = QMAG_W'(1 << (OUT_W - 1));

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                   state;
  logic [5:0]               cnt;
  logic signed [IN_W-1:0]   coef_buf [64];
  logic                     load;
  logic [5:0]               zz_idx;
  logic signed [IN_W-1:0]   coef;
  logic                     neg;
  logic [IN_W:0]            mag;
  logic [PROD_W-1:0]        prod;
  logic [PROD_W-1:0]        rounded;
  logic [QMAG_W-1:0]        qmag;
  logic [OUT_W-1:0]         qval;

  assign in_ready = (state == S_IDLE);
  assign load     = !out_valid || out_ready;

  // Capture the whole block on an accepted input beat
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      for (int i = 0; i < 64; i++) begin
        coef_buf[i] <= in_block[i*IN_W +: IN_W];
      end
    end
  end

  // Quantize the coefficient at zigzag position cnt: round half away from zero, then saturate
  always_comb begin
    zz_idx  = 6'(ZZ[cnt]);
    coef    = coef_buf[zz_idx];
    neg     = coef[IN_W-1];
    mag     = {coef[IN_W-1], coef};
    if (neg) begin
      mag = -mag;
    end
    prod    = PROD_W'(mag) * PROD_W'(RECIP[zz_idx]);
    rounded = prod + (PROD_W'(1) << (RECIP_FRAC - 1));
    qmag    = rounded[PROD_W-1:RECIP_FRAC];
    if (neg) begin
      if (qmag >= NEG_LIM) begin
        qval = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        qval = -qmag[OUT_W-1:0];
      end
    end else begin
      if (qmag > POS_LIM) begin
        qval = {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        qval = qmag[OUT_W-1:0];
      end
    end
  end

  // Control FSM and output register: accept in IDLE, issue 64 zigzag beats in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (in_valid) begin
            cnt   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (load) begin
            out_data  <= qval;
            out_index <= cnt;
            out_last  <= (cnt == 6'd63);
            out_valid <= 1'b1;
            cnt       <= cnt + 6'd1;
            if (cnt == 6'd63) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Testbench for dct_quant_zigzag: table of single-coefficient blocks, randomized
// blocks against a reference model, back-pressure, back-to-back and reset sequences.
module tb_dct_quant_zigzag;

  localparam int IN_W  = 32;
  localparam int OUT_W = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic [64*IN_W-1:0]   in_block;
  logic                 in_ready;
  logic                 out_valid;
  logic [OUT_W-1:0]     out_data;
  logic [5:0]           out_index;
  logic                 out_last;
  logic                 out_ready;

  dct_quant_zigzag #(.IN_W(IN_W), .OUT_W(OUT_W), .RECIP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_block(in_block),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int qtab [64] = '{
    16, 11, 10, 16,  24,  40,  51,  61,
    12, 12, 14, 19,  26,  58,  60,  55,
    14, 13, 16, 24,  40,  57,  69,  56,
    14, 17, 22, 29,  51,  87,  80,  62,
    18, 22, 37, 56,  68, 109, 103,  77,
    24, 35, 55, 64,  81, 104, 113,  92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103,  99
  };
  int zz_model [64];
  int recip_model [64];

  longint blk_vals [64];
  int     exp_data [64];
  int     got_data [64];
  int     got_idx  [64];
  int     got_last [64];
  int     n_got;
  int     first_cyc;
  int     last_cyc;
  int     wait_cycles;

  typedef struct {
    string  name;
    int     pos;
    longint val;
    int     k;
    int     expected;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input longint actual, input longint expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Zigzag walks anti-diagonals, alternating direction; reciprocals from real division
  function automatic void build_model();
    int k;
    k = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
          zz_model[k] = r * 8 + (s - r);
          k++;
        end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
          zz_model[k] = r * 8 + (s - r);
          k++;
        end
      end
    end
    for (int i = 0; i < 64; i++) begin
      recip_model[i] = $rtoi(65536.0 / qtab[i] + 0.5);
    end
  endfunction

  function automatic int quant_model(input longint c, input int r);
    longint mag;
    longint q;
    mag = (c < 0) ? -c : c;
    q = (mag * r + 32768) / 65536;
    if (c < 0) q = -q;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return int'(q);
  endfunction

  function automatic void compute_expected();
    for (int k = 0; k < 64; k++) begin
      exp_data[k] = quant_model(blk_vals[zz_model[k]], recip_model[zz_model[k]]);
    end
  endfunction

  function automatic void clear_block();
    for (int i = 0; i < 64; i++) blk_vals[i] = 0;
  endfunction

  function automatic void random_block(input int mode);
    for (int i = 0; i < 64; i++) begin
      if (mode == 0)      blk_vals[i] = longint'(int'($urandom_range(0, 8000)) - 4000);
      else if (mode == 1) blk_vals[i] = longint'(int'($urandom_range(0, 400000)) - 200000);
      else                blk_vals[i] = longint'($signed($urandom()));
    end
  endfunction

  // Present blk_vals for one handshake; returns at #1 after the accepting edge
  task automatic apply_stimulus();
    wait_cycles = 0;
    while (!in_ready && wait_cycles < 200) begin
      @(posedge clk); #1;
      wait_cycles++;
    end
    if (!in_ready) check("in_ready wait", 0, 1);
    for (int i = 0; i < 64; i++) begin
      in_block[i*IN_W +: IN_W] = blk_vals[i][IN_W-1:0];
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_block = {64{$urandom()}};
    check("bubble after accept out_valid", out_valid, 0);
  endtask

  // Collect beats; optional stall at index stall_at, optional early stop at index stop_at
  task automatic receive(input int stall_at, input int stall_len, input int stop_at);
    int  cyc;
    bit  stalled;
    bit  stopped;
    int  held_data;
    int  held_last;
    cyc = 0; stalled = 0; stopped = 0;
    n_got = 0; first_cyc = -1; last_cyc = -1;
    while (n_got < 64 && cyc < 400 && !stopped) begin
      if (out_valid && out_ready) begin
        if (stall_at >= 0 && !stalled && int'(out_index) == stall_at) begin
          held_data = int'($signed(out_data));
          held_last = int'(out_last);
          out_ready = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            @(posedge clk); #1;
            cyc++;
            check("stall out_valid", out_valid, 1);
            check("stall out_index", out_index, stall_at);
            check("stall out_data", $signed(out_data), held_data);
            check("stall out_last", out_last, held_last);
            check("stall in_ready", in_ready, 0);
          end
          out_ready = 1'b1;
          stalled = 1;
        end
        if (stop_at >= 0 && int'(out_index) == stop_at) begin
          stopped = 1;
        end else begin
          got_data[n_got] = int'($signed(out_data));
          got_idx[n_got]  = int'(out_index);
          got_last[n_got] = int'(out_last);
          if (n_got == 0) first_cyc = cyc;
          last_cyc = cyc;
          n_got++;
        end
      end
      if (n_got < 64 && !stopped) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!stopped && n_got < 64) check("stream timeout beats", n_got, 64);
  endtask

  // Compare a full collected stream against the model and the timing rules
  task automatic check_output(input int stall_len);
    compute_expected();
    check("first beat latency", first_cyc, 1);
    check("stream span cycles", last_cyc - first_cyc, 63 + stall_len);
    check("in_ready after last", in_ready, 1);
    for (int k = 0; k < n_got; k++) begin
      check($sformatf("data k=%0d", k), got_data[k], exp_data[k]);
      check($sformatf("index k=%0d", k), got_idx[k], k);
      check($sformatf("last k=%0d", k), got_last[k], (k == 63) ? 1 : 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{"dc 1600",    0,  1600,           0,  100};
    vecs[1]  = '{"round 24",   0,  24,             0,  2};
    vecs[2]  = '{"round -24",  0, -24,             0, -2};
    vecs[3]  = '{"round 8",    0,  8,              0,  1};
    vecs[4]  = '{"round 7",    0,  7,              0,  0};
    vecs[5]  = '{"sat +2^20",  0,  64'sd1048576,   0,  2047};
    vecs[6]  = '{"sat -2^20",  0, -64'sd1048576,   0, -2048};
    vecs[7]  = '{"sat -2^31",  0, -64'sd2147483648, 0, -2048};
    vecs[8]  = '{"x1 55",      1,  55,             1,  5};
    vecs[9]  = '{"x8 36",      8,  36,             2,  3};
    vecs[10] = '{"x63 -500",   63, -500,           63, -5};

    build_model();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_block  = '0;
    out_ready = 1'b1;
    #12;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_index", out_index, 0);
    check("reset out_last", out_last, 0);
    check("reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 11; v++) begin
      clear_block();
      blk_vals[vecs[v].pos] = vecs[v].val;
      apply_stimulus();
      receive(-1, 0, -1);
      check({vecs[v].name, " target"}, got_data[vecs[v].k], vecs[v].expected);
      check_output(0);
    end

    clear_block();
    blk_vals[1] = 55;
    blk_vals[8] = 36;
    apply_stimulus();
    receive(-1, 0, -1);
    check("combo k1", got_data[1], 5);
    check("combo k2", got_data[2], 3);
    check("combo k3", got_data[3], 0);
    check_output(0);

    for (int b = 0; b < 6; b++) begin
      random_block(b % 3);
      apply_stimulus();
      check("back-to-back wait", wait_cycles, 0);
      if (b == 1) begin
        receive(10, 5, -1);
        check_output(5);
      end else begin
        receive(-1, 0, -1);
        check_output(0);
      end
    end

    random_block(0);
    apply_stimulus();
    receive(-1, 0, 30);
    check("pre-reset index", out_index, 30);
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_index", out_index, 0);
    check("async reset out_data", out_data, 0);
    check("async reset out_last", out_last, 0);
    check("async reset in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no resume out_valid", out_valid, 0);
    check("post-reset in_ready", in_ready, 1);
    random_block(1);
    apply_stimulus();
    receive(-1, 0, -1);
    check_output(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dct_quant_zigzag.md
Name: dct_quant_zigzag

Overview:
Downstream stage of the 8x8 2-D DCT core. It accepts one whole 64-coefficient block per ready/valid beat, stores it, and quantizes each coefficient with the fixed JPEG luminance table (Annex K, quality 50) using reciprocal multiplication. It then emits the quantized coefficients one per beat in JPEG zigzag order to the entropy-coding stage.

Parameters:
IN_W, 32, width of each signed input coefficient (integer, row-major block of 64)
OUT_W, 12, width of each signed quantized output coefficient
RECIP_W, 16, width of the unsigned reciprocal constants; RECIP_FRAC fixed at 16

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_block holds a valid 8x8 coefficient block
in_block  input  64*IN_W  row-major {X63..X0}; Xi = in_block[i*IN_W +: IN_W]
in_ready  output  1  block accepted on the edge where in_valid && in_ready
out_valid  output  1  out_data/out_index/out_last valid
out_data  output  OUT_W  quantized coefficient, signed
out_index  output  6  zigzag position k, 0..63
out_last  output  1  high with k = 63
out_ready  input  1  downstream back-pressure

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: out_valid=0, out_data=0, out_index=0, out_last=0, state=S_IDLE, issue counter=0. in_ready=1 out of reset, since it is decoded combinationally from S_IDLE.
- Storage: coef_buf[0:63] of IN_W. Written only on an accepted input beat.
- FSM S_IDLE: in_ready=1. On in_valid, capture all 64 coefficients, set cnt=0, and go to S_ISSUE.
- FSM S_ISSUE: in_ready=0.
  - load = !out_valid || out_ready.
  - On load, the output register takes Q(coef_buf[zz[cnt]], R[zz[cnt]]), out_index=cnt, out_last=(cnt==63), out_valid=1, and cnt increments.
  - When cnt==63 is loaded, go to S_IDLE.
- Output drain: in S_IDLE, out_ready with no new load sets out_valid=0. The final element can still be held in the output register while the next block is being captured; the output register is independent of coef_buf.
- zz[] is the standard JPEG zigzag: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28,35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63.
- R[i] = round(65536 / Qtab[i]), where Qtab is the Annex K luminance table in raster order (Qtab[0]=16, Qtab[1]=11, Qtab[8]=12, ...). Constants are held in ROM.
- Quantization Q(c,R):
  - m = |c| * R, a product of at least IN_W+RECIP_W bits.
  - q = (m + 2^15) >> 16; this is round-half-away-from-zero.
  - Apply the sign of c.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - |c| is computed in IN_W+1 bits, so c = -2^(IN_W-1) is legal and saturates to the negative limit.
- Latency: accept edge E0 -> element k=0 valid after E1.
- Throughput: without back-pressure, one element per cycle. Back-to-back blocks run at 65 cycles each: the last load at E64, state IDLE after E64, next accept at E65, and one bubble cycle.
- Back-pressure: while out_valid && !out_ready, out_data, out_index and out_last hold stable and cnt does not advance.
- in_valid in S_ISSUE is ignored, with no capture. The upstream holds its block under valid/ready rules.
- Reset mid-block: the block is abandoned. Outputs return to reset values immediately (asynchronously), and no partial block resumes after reset.

Test Plan:
- DC-only block X0=1600, others 0, out_ready=1 -> 64 beats on consecutive cycles; k=0 gives 100, all others 0; out_last only on beat 64, with out_index=63.
- Rounding: X0=24 -> 2; X0=-24 -> -2; X0=8 -> 1 (0.5 rounds away); X0=7 -> 0.
- Zigzag and reciprocal: X1=55, X8=36, others 0 -> k=1 gives 5, k=2 gives 3, every other k gives 0.
- Saturation: X0=2^20 -> 2047; X0=-2^20 -> -2048; X0=-2^31 -> -2048.
- Back-pressure: drop out_ready for 5 cycles at k=10 -> outputs stable with out_index=10; the sequence resumes with no loss or duplication. in_ready stays 0 until k=63 is loaded.
- Back-to-back blocks plus reset: second block accepted exactly one cycle after the k=63 load. Assert rst_n low at k=30 -> out_valid=0 at once; after release, in_ready=1 and a new block streams from k=0.
